// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI4 burst arbiter and its round-robin picker.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  function automatic int clog2_min1(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic priority search: first set req bit at or after (ptr+1) mod NUM.
module rr_pick
  import axi_arb_pkg::*;
#(
  parameter int NUM   = 8,
  parameter int NSIZE = clog2_min1(NUM)
) (
  input  logic [NUM-1:0]   req,
  input  logic [NSIZE-1:0] ptr,
  output logic [NSIZE-1:0] idx,
  output logic             any
);

  localparam int SW = NSIZE + 1;

  logic [2*NUM-1:0] dbl_s;
  logic [NUM-1:0]   rot_s;
  logic [SW-1:0]    start_s;
  logic [SW-1:0]    sum_s;
  logic [NSIZE-1:0] wrap_s;

  // Rotate req so the search start lands on bit 0, then take the lowest set bit.
  always_comb begin
    start_s = (ptr >= NSIZE'(NUM - 1)) ? SW'(1'b0) : ({1'b0, ptr} + SW'(1'b1));
    dbl_s   = {req, req};
    rot_s   = NUM'(dbl_s >> start_s);
    idx     = '0;
    sum_s   = '0;
    wrap_s  = '0;
    // Walk from the highest offset down so the lowest offset is the final winner.
    for (int i = NUM - 1; i >= 0; i--) begin
      sum_s  = start_s + SW'(i);
      wrap_s = NSIZE'((sum_s >= SW'(NUM)) ? (sum_s - SW'(NUM)) : sum_s);
      idx    = rot_s[i] ? wrap_s : idx;
    end
    any = |req;
  end

endmodule

// File: rtl/axi4_burst_arbiter.sv
// Burst-level arbiter for one AXI4 channel: holds a path from address handshake
// to burst completion, round-robin between requesters, with a grant timeout.
module axi4_burst_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM     = 8,
  parameter int TIMEOUT = 4096,
  localparam int NSIZE  = clog2_min1(NUM),
  localparam int TW     = $clog2(TIMEOUT + 1)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [NUM-1:0]   req,
  input  logic             addr_hs,
  input  logic             done,
  output logic             grant_vld,
  output logic [NSIZE-1:0] grant_idx,
  output logic [NUM-1:0]   grant_oh,
  output logic             timeout_err,
  output logic [NSIZE-1:0] err_idx
);

  arb_state_t       state_r;
  logic             grant_vld_r;
  logic [NSIZE-1:0] grant_idx_r;
  logic [NUM-1:0]   grant_oh_r;
  logic             timeout_err_r;
  logic [NSIZE-1:0] err_idx_r;
  logic [TW-1:0]    cnt_r;
  logic [NSIZE-1:0] ptr_r;

  logic [NSIZE-1:0] pick_idx_s;
  logic             pick_any_s;
  logic [TW-1:0]    cnt_inc_s;
  logic             tmo_hit_s;
  logic             complete_s;
  logic             busy_s;
  logic             tmo_fire_s;
  logic [NSIZE-1:0] ptr_upd_s;

  function automatic logic [NUM-1:0] to_oh(input logic [NSIZE-1:0] i);
    return NUM'(1'b1) << i;
  endfunction

  rr_pick #(
    .NUM   (NUM),
    .NSIZE (NSIZE)
  ) u_pick (
    .req (req),
    .ptr (ptr_r),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  // Timeout detection; a completing event in the same cycle always takes precedence.
  always_comb begin
    cnt_inc_s = (cnt_r == TW'(TIMEOUT)) ? cnt_r : (cnt_r + TW'(1'b1));
    tmo_hit_s = (cnt_r == TW'(TIMEOUT - 1));
    case (state_r)
      ADDR:    complete_s = addr_hs;
      DATA:    complete_s = done;
      default: complete_s = 1'b0;
    endcase
    busy_s     = (state_r != IDLE);
    tmo_fire_s = busy_s && tmo_hit_s && !complete_s;
    if (NUM == 1) begin
      ptr_upd_s = '0;
    end else begin
      ptr_upd_s = grant_idx_r;
    end
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      grant_vld_r   <= 1'b0;
      grant_idx_r   <= '0;
      grant_oh_r    <= '0;
      timeout_err_r <= 1'b0;
      err_idx_r     <= '0;
      cnt_r         <= '0;
      ptr_r         <= NSIZE'(NUM - 1);
    end else begin
      timeout_err_r <= tmo_fire_s;
      if (tmo_fire_s) begin
        err_idx_r <= grant_idx_r;
      end
      if (busy_s) begin
        cnt_r <= cnt_inc_s;
      end
      case (state_r)
        IDLE: begin
          if (pick_any_s) begin
            state_r     <= ADDR;
            grant_vld_r <= 1'b1;
            grant_idx_r <= pick_idx_s;
            grant_oh_r  <= to_oh(pick_idx_s);
            cnt_r       <= '0;
          end
        end
        ADDR: begin
          if (addr_hs) begin
            state_r <= DATA;
          end else if (tmo_fire_s) begin
            state_r     <= IDLE;
            grant_vld_r <= 1'b0;
            grant_oh_r  <= '0;
            ptr_r       <= ptr_upd_s;
          end
        end
        DATA: begin
          if (done || tmo_fire_s) begin
            state_r     <= IDLE;
            grant_vld_r <= 1'b0;
            grant_oh_r  <= '0;
            ptr_r       <= ptr_upd_s;
          end
        end
        default: begin
          state_r     <= IDLE;
          grant_vld_r <= 1'b0;
          grant_oh_r  <= '0;
        end
      endcase
    end
  end

  assign grant_vld   = grant_vld_r;
  assign grant_idx   = grant_idx_r;
  assign grant_oh    = grant_oh_r;
  assign timeout_err = timeout_err_r;
  assign err_idx     = err_idx_r;

endmodule

// File: tb/tb_axi4_burst_arbiter.sv
// Directed table-driven bench for axi4_burst_arbiter (NUM=4, TIMEOUT=16),
// plus hand-written timeout, collision and mid-burst reset sequences.
module tb_axi4_burst_arbiter;

  logic       clock;
  logic       rst;
  logic [3:0] req;
  logic       addr_hs;
  logic       done;
  logic       grant_vld;
  logic [1:0] grant_idx;
  logic [3:0] grant_oh;
  logic       timeout_err;
  logic [1:0] err_idx;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] req;
    logic       hs;
    logic       dn;
    logic       exp_vld;
    logic [1:0] exp_idx;
  } vec_t;

  vec_t vecs[$];

  axi4_burst_arbiter #(
    .NUM     (4),
    .TIMEOUT (16)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .req         (req),
    .addr_hs     (addr_hs),
    .done        (done),
    .grant_vld   (grant_vld),
    .grant_idx   (grant_idx),
    .grant_oh    (grant_oh),
    .timeout_err (timeout_err),
    .err_idx     (err_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic [3:0] r, input logic h, input logic d,
                     input logic v, input logic [1:0] i);
    vec_t t;
    t.req = r; t.hs = h; t.dn = d; t.exp_vld = v; t.exp_idx = i;
    vecs.push_back(t);
  endtask

  function automatic logic [3:0] exp_oh(input logic v, input logic [1:0] i);
    logic [3:0] one;
    one = 4'b0001;
    return v ? (one << i) : 4'b0000;
  endfunction

  initial begin
    int vcnt;
    logic dropped;

    rst = 1'b1; req = 4'b0000; addr_hs = 1'b0; done = 1'b0;

    // Each row: inputs during a cycle, expected outputs after the next edge.
    add(4'b1010, 1'b0, 1'b0, 1'b1, 2'd1);  // first grant from ptr=3 -> 1
    add(4'b1010, 1'b1, 1'b0, 1'b1, 2'd1);
    add(4'b1010, 1'b0, 1'b1, 1'b0, 2'd1);  // done -> one idle cycle
    add(4'b1010, 1'b0, 1'b0, 1'b1, 2'd3);  // rotates past 1 to 3
    add(4'b0000, 1'b1, 1'b0, 1'b1, 2'd3);
    add(4'b0000, 1'b0, 1'b1, 1'b0, 2'd3);
    add(4'b0000, 1'b0, 1'b0, 1'b0, 2'd3);  // no request: idle, idx held
    add(4'b1111, 1'b0, 1'b0, 1'b1, 2'd0);  // fairness rotation starts at 0
    add(4'b1111, 1'b1, 1'b0, 1'b1, 2'd0);
    add(4'b1111, 1'b0, 1'b1, 1'b0, 2'd0);
    add(4'b1111, 1'b0, 1'b0, 1'b1, 2'd1);
    add(4'b1111, 1'b0, 1'b1, 1'b1, 2'd1);  // done in ADDR ignored
    add(4'b1111, 1'b1, 1'b0, 1'b1, 2'd1);
    add(4'b1111, 1'b1, 1'b0, 1'b1, 2'd1);  // addr_hs in DATA ignored
    add(4'b1111, 1'b0, 1'b1, 1'b0, 2'd1);
    add(4'b1111, 1'b0, 1'b0, 1'b1, 2'd2);
    add(4'b1011, 1'b0, 1'b0, 1'b1, 2'd2);  // owner drops req in ADDR
    add(4'b0001, 1'b0, 1'b0, 1'b1, 2'd2);
    add(4'b0001, 1'b1, 1'b0, 1'b1, 2'd2);
    add(4'b1111, 1'b0, 1'b1, 1'b0, 2'd2);
    add(4'b1111, 1'b0, 1'b0, 1'b1, 2'd3);
    add(4'b1111, 1'b1, 1'b0, 1'b1, 2'd3);
    add(4'b1111, 1'b0, 1'b1, 1'b0, 2'd3);
    add(4'b1111, 1'b0, 1'b0, 1'b1, 2'd0);  // wraps back to 0
    add(4'b0000, 1'b1, 1'b0, 1'b1, 2'd0);
    add(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0);

    repeat (2) @(posedge clock);
    #1;
    chk("rst_vld", 32'(grant_vld), 32'd0);
    chk("rst_idx", 32'(grant_idx), 32'd0);
    chk("rst_oh", 32'(grant_oh), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_eidx", 32'(err_idx), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      req = vecs[i].req; addr_hs = vecs[i].hs; done = vecs[i].dn;
      step();
      chk($sformatf("row%0d_vld", i), 32'(grant_vld), 32'(vecs[i].exp_vld));
      chk($sformatf("row%0d_idx", i), 32'(grant_idx), 32'(vecs[i].exp_idx));
      chk($sformatf("row%0d_oh", i), 32'(grant_oh), 32'(exp_oh(vecs[i].exp_vld, vecs[i].exp_idx)));
      chk($sformatf("row%0d_terr", i), 32'(timeout_err), 32'd0);
    end
    addr_hs = 1'b0; done = 1'b0;

    // Timeout: grant to 2, never handshake; 16 owned cycles then a pulse.
    req = 4'b1100;
    step();
    chk("tmo_first_vld", 32'(grant_vld), 32'd1);
    chk("tmo_first_idx", 32'(grant_idx), 32'd2);
    vcnt = 1;
    dropped = 1'b0;
    for (int k = 0; k < 40 && !dropped; k++) begin
      step();
      if (grant_vld) begin
        vcnt++;
        chk("tmo_no_early_err", 32'(timeout_err), 32'd0);
      end else begin
        dropped = 1'b1;
      end
    end
    chk("tmo_dropped", 32'(dropped), 32'd1);
    chk("tmo_vld_cycles", 32'(vcnt), 32'd16);
    chk("tmo_pulse", 32'(timeout_err), 32'd1);
    chk("tmo_eidx", 32'(err_idx), 32'd2);
    step();
    chk("tmo_pulse_end", 32'(timeout_err), 32'd0);
    chk("tmo_next_vld", 32'(grant_vld), 32'd1);
    chk("tmo_next_idx", 32'(grant_idx), 32'd3);
    chk("tmo_eidx_held", 32'(err_idx), 32'd2);

    // Collision: done on the last allowed cycle wins over the timeout.
    addr_hs = 1'b1;
    step();
    addr_hs = 1'b0;
    repeat (14) step();
    chk("col_still_vld", 32'(grant_vld), 32'd1);
    chk("col_still_idx", 32'(grant_idx), 32'd3);
    done = 1'b1;
    req = 4'b0000;
    step();
    done = 1'b0;
    chk("col_vld", 32'(grant_vld), 32'd0);
    chk("col_terr", 32'(timeout_err), 32'd0);
    step();
    chk("col_terr_next", 32'(timeout_err), 32'd0);
    chk("col_eidx", 32'(err_idx), 32'd2);

    // Mid-burst reset: grant to 3 in DATA, reset drops it without a clock edge.
    req = 4'b1000;
    step();
    chk("mrst_grant_idx", 32'(grant_idx), 32'd3);
    addr_hs = 1'b1;
    step();
    addr_hs = 1'b0;
    chk("mrst_in_data", 32'(grant_vld), 32'd1);
    rst = 1'b1;
    #1;
    chk("mrst_async_vld", 32'(grant_vld), 32'd0);
    chk("mrst_async_oh", 32'(grant_oh), 32'd0);
    chk("mrst_async_terr", 32'(timeout_err), 32'd0);
    chk("mrst_async_eidx", 32'(err_idx), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("mrst_regrant_vld", 32'(grant_vld), 32'd1);
    chk("mrst_regrant_idx", 32'(grant_idx), 32'd3);
    chk("mrst_regrant_oh", 32'(grant_oh), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
